// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the N-digit seven-segment multiplexer.
// Segment patterns are {g,f,e,d,c,b,a} in active-low form.
package sevenseg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

  // Index k holds the pattern for hex digit k.
  localparam logic [15:0][6:0] HEX_AL = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/sevenseg_mux_n_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_al
);

  assign seg_al = HEX_AL[nibble];

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with registered seg/sel.
// Optional anti-ghosting dead-time between digits: define SEVENSEG_DEADTIME_EN.
module sevenseg_mux_n
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned DIGIT_CYCLES   = 60_000,
  parameter int unsigned DEAD_CYCLES    = 600,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_tick
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         SHOW_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         idx_next;
  logic                  show;
  logic [3:0]            nib;
  logic                  en_cur;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            dec_al;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_tick_q, frame_tick_d;

  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

`ifdef SEVENSEG_DEADTIME_EN
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = idx_next;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  assign show = (state_q == SHOW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SHOW;
    else        state_q <= state_d;
  end
`else
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == SHOW_LAST) begin
      cnt_d = '0;
      idx_d = idx_next;
    end
  end

  assign show = 1'b1;
`endif

  always_comb begin
    nib    = '0;
    en_cur = 1'b0;
    onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = digits[4*k +: 4];
        en_cur    = digit_en[k];
        onehot[k] = 1'b1;
      end
    end
  end

  sevenseg_decoder u_dec (
    .nibble (nib),
    .seg_al (dec_al)
  );

  // Outputs are computed from the current slot position, so the registered
  // outputs show slot position p on the edge that leaves position p.
  always_comb begin
    seg_d        = SEG_OFF;
    sel_d        = SEL_OFF;
    frame_tick_d = show && (cnt_q == '0) && (idx_q == '0);
    if (show && en_cur) begin
      seg_d = SEG_ACTIVE_LOW ? dec_al : ~dec_al;
      sel_d = SEL_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_OFF;
      sel_q        <= SEL_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Scoreboard bench for sevenseg_mux_n: 4 digits, 8-cycle slots, active-low outputs.
// Honours SEVENSEG_DEADTIME_EN so the same bench covers both builds.
module tb_sevenseg_mux_n;

  localparam int unsigned ND = 4;
  localparam int unsigned DC = 8;
  localparam int unsigned DD = 2;
`ifdef SEVENSEG_DEADTIME_EN
  localparam int unsigned DP = DC + DD;
`else
  localparam int unsigned DP = DC;
`endif
  localparam int unsigned FP = ND * DP;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
    logic       ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h8F10;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic        frame_tick;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned t = 0;

  sevenseg_mux_n #(
    .NUM_DIGITS     (ND),
    .DIGIT_CYCLES   (DC),
    .DEAD_CYCLES    (DD),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .seg        (seg),
    .sel        (sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference: position within the frame since release decides digit, blank gap and tick.
  function automatic exp_t model(input int unsigned tt, input logic [15:0] dg,
                                 input logic [3:0] en, input logic rst_n);
    exp_t        e;
    int unsigned p, d, w;
    e.seg = 7'b1111111;
    e.sel = 4'b1111;
    e.ft  = 1'b0;
    if (!rst_n) return e;
    p    = tt % FP;
    d    = p / DP;
    w    = p % DP;
    e.ft = (p == 0);
    if (w < DC && en[d]) begin
      e.seg = HEX[dg[4*d +: 4]];
      e.sel = ~(4'b0001 << d);
    end
    return e;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  // Drive inputs at the falling edge and predict the outputs after the next rising edge.
  task automatic step(input logic rst_n, input logic [15:0] dg, input logic [3:0] en);
    @(negedge clk);
    reset    = rst_n;
    digits   = dg;
    digit_en = en;
    q.push_back(model(t, dg, en, rst_n));
    if (rst_n) t++;
    else       t = 0;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("seg", 32'(seg), 32'(e.seg));
      check("sel", 32'(sel), 32'(e.sel));
      check("frame_tick", 32'(frame_tick), 32'(e.ft));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    logic [15:0] dg;
    logic [3:0]  en;
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 16'h8F10, 4'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_sel", 32'(sel), 32'hF);

    for (int i = 0; i < 2 * FP; i++) step(1'b1, 16'h8F10, 4'hF);
    for (int i = 0; i < FP; i++) step(1'b1, 16'h8F10, 4'b1011);

    // Slot 0 digit changes 0 -> 8 mid-slot.
    dg = 16'h8F10;
    for (int i = 0; i < FP; i++) begin
      if ((t % FP) == 3) dg[3:0] = 4'h8;
      step(1'b1, dg, 4'hF);
    end

    dg = 16'h8F10;
    en = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) dg = 16'($urandom);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
      step(1'b1, dg, en);
    end

    // Reach slot 2, cycle 5, then drop reset between clock edges.
    for (int i = 0; i < 2 * FP && (t % FP) != 2 * DP + 6; i++) step(1'b1, 16'h8F10, 4'hF);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_seg", 32'(seg), 32'h7F);
    check("async_reset_sel", 32'(sel), 32'hF);
    check("async_reset_ft", 32'(frame_tick), 32'h0);
    t = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 16'h8F10, 4'hF);
    for (int i = 0; i < FP + 3; i++) step(1'b1, 16'h8F10, 4'hF);

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_mux_n.md
# sevenseg_mux_n

Parametrised N-digit time-multiplexed seven-segment driver: generalises the two-digit PNP-switched display of the Lab2 design to NUM_DIGITS digits. It has a configurable per-digit on-time, selectable output polarities and per-digit blanking. An optional anti-ghosting dead-time can be compiled in. It sits between the hex-nibble sources (switch inputs, sum logic) and the board's shared segment bus and digit-select transistors, running directly on the 12 MHz board clock.

## Interface
- NUM_DIGITS, 2: digits multiplexed; legal range 1..8.
- DIGIT_CYCLES, 60_000: clk cycles each digit is driven (60_000 at 12 MHz gives 100 Hz switching); minimum 2.
- DEAD_CYCLES, 600: blank cycles between digits; used only with the dead-time macro; minimum 1.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.
- SEL_ACTIVE_LOW, 1: 1 means the selected digit is driven 0 (PNP high-side).
- clk  input  1  12 MHz board clock.
- reset  input  1  asynchronous, active-low reset.
- digits  input  4*NUM_DIGITS  hex nibbles; digit k = digits[4k+3:4k].
- digit_en  input  NUM_DIGITS  1 = digit k shown in its slot; 0 = slot blanked.
- seg  output  7  segment bus {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- sel  output  NUM_DIGITS  one-hot-active digit selects, polarity per SEL_ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Slot counter cnt runs 0..DIGIT_CYCLES-1. Digit index idx runs 0..NUM_DIGITS-1.
- When cnt reaches its terminal count, cnt returns to 0 and idx advances.
- idx wraps from NUM_DIGITS-1 to 0. frame_tick is high for exactly the one cycle in which idx is 0 and the first slot of that digit begins.
- Disabled digits still consume their slot, so the refresh rate is independent of digit_en.
- In a disabled slot, seg is all-off and every sel bit is inactive.
- The hex decode covers 0-F (active-low values below):
  - 0 = 1000000
  - 8 = 0000000
  - F = 0001110
  - SEG_ACTIVE_LOW=0 inverts each value bitwise.
- seg and sel are registered. digits and digit_en are sampled every cycle, so changing them mid-slot updates the outputs one cycle later.
- At most one sel bit is ever active. seg is never driven with lit segments while no sel bit is active.
- NUM_DIGITS=1: sel[0] is permanently active (when enabled); frame_tick fires once every slot.
- Reset values (reset low, asynchronous):
  - cnt=0, idx=0, state=SHOW.
  - seg = all-off, sel = all-inactive, frame_tick = 0.
- Reset asserted mid-slot blanks the outputs immediately.
- On the first clk edge after release, the outputs show digit 0 (if enabled) and frame_tick pulses.

## Timing
- Latency from a digits/digit_en change to seg/sel: 1 cycle.
- Digit period: DIGIT_CYCLES without the dead-time macro, DIGIT_CYCLES+DEAD_CYCLES with it.
- Frame period: NUM_DIGITS × digit period.
- With dead-time, the state machine has two states:
  - SHOW: lasts DIGIT_CYCLES cycles. On terminal count it moves to BLANK.
  - BLANK: lasts DEAD_CYCLES cycles with seg all-off and sel all-inactive. On exit idx advances and the state returns to SHOW.
- frame_tick coincides with the first SHOW cycle of digit 0.
- Counter widths come from $clog2 of the larger of DIGIT_CYCLES and DEAD_CYCLES, so there is no overflow at the maxima.

## Configuration
- SEVENSEG_DEADTIME_EN defined: the BLANK state and the DEAD_CYCLES interval are built in. This prevents ghosting while the PNP transistors turn off.
- SEVENSEG_DEADTIME_EN undefined: BLANK is not synthesised and DEAD_CYCLES is ignored. idx advances directly on the SHOW terminal count, giving back-to-back slots (the legacy two-digit behaviour).

## Structure
- Package sevenseg_pkg holds:
  - the state enum (SHOW, BLANK);
  - SEG_OFF_AL = 7'b1111111;
  - the 16-entry hex-to-segment table in active-low form.
- Sub-module sevenseg_decoder (combinational nibble -> 7-bit active-low pattern) is instantiated once on the selected nibble. Polarity inversion happens in the parent, before the output register.

## Test plan
Bench parameters: NUM_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2, both polarities active-low.
- Reset hold then release, digits=16'h8F10, all enabled -> outputs all-off/inactive during reset. First edge after release: sel=1110, seg=1000000 (0), frame_tick=1 for 1 cycle.
- Free run, dead-time off -> sel steps 1110, 1101, 1011, 0111 every 8 cycles. seg shows 0, 1, F, 8. frame_tick repeats every 32 cycles.
- Free run with SEVENSEG_DEADTIME_EN -> 2 cycles of sel=1111 and seg=1111111 between every pair of digits. frame_tick period 40 cycles.
- digit_en=4'b1011 -> slot 2 shows sel=1111 and seg=1111111 for 8 cycles; frame period unchanged.
- Change digits[3:0] from 0 to 8 mid-slot 0 -> seg goes 1000000 to 0000000 exactly 1 cycle later.
- reset asserted at cycle 5 of slot 2 -> outputs blank the same instant. After release, the scan restarts at digit 0 with frame_tick.
